// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU pipeline.
// Holds the register index type and the load depth default.
package cpu_pkg;

   typedef logic [4:0] reg_idx_t;

   localparam int LOAD_DEPTH_DEF = 4;

   // True when a non-zero source register names the given destination.
   function automatic logic src_hit(reg_idx_t src, reg_idx_t dst);
      return (src != '0) && (src == dst);
   endfunction

endpackage

// File: rtl/cpu_writeback_if.sv
// Memory load-response bundle into the writeback stage.
// Responses are in order and cannot be back-pressured.
interface cpu_writeback_if;

   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (output mem_rvalid, output mem_rdata);
   modport slave  (input  mem_rvalid, input  mem_rdata);

endinterface

// File: rtl/cpu_load_fifo.sv
// In-order tag FIFO of outstanding load destinations.
// Exposes every slot and its valid bit for hazard checks.
module cpu_load_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = LOAD_DEPTH_DEF
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     enq,
   input  reg_idx_t enq_tag,
   input  logic     deq,
   output reg_idx_t head,
   output logic     empty,
   output logic     full,
   output logic     valid [DEPTH],
   output reg_idx_t entries [DEPTH]
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count_q;
   reg_idx_t      mem_q [DEPTH];
   logic          do_enq;
   logic          do_deq;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign do_enq  = enq && !full;
   assign do_deq  = deq && !empty;
   assign head    = mem_q[rd_ptr];
   assign entries = mem_q;

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] off;
         off      = PW'(i) - rd_ptr;
         valid[i] = ({1'b0, off} < count_q);
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + PW'(1);
         if (do_deq) rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_enq, do_deq})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Tag storage needs no reset; the count gates what is visible.
   always_ff @(posedge clock) begin
      if (do_enq) mem_q[wr_ptr] <= enq_tag;
   end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: merges ALU results and load responses.
// Load responses own the write port; ALU ops stall behind them.
module cpu_writeback
   import cpu_pkg::*;
#(
   parameter int LOAD_DEPTH = LOAD_DEPTH_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  reg_idx_t        p3_dest_reg,
   input  logic            p3_is_load,
   input  logic            p4_valid,
   input  reg_idx_t        p4_dest_reg,
   input  logic [31:0]     p4_result,
   input  logic            p4_is_load,
   cpu_writeback_if.slave  mem,
   input  reg_idx_t        p2_reg_a,
   input  reg_idx_t        p2_reg_b,
   input  logic            p2_literal_b,
   output reg_idx_t        p5_dest_reg,
   output logic [31:0]     p5_result,
   output logic            p2_stall,
   output logic            p4_stall,
   output logic            wb_error
);

   reg_idx_t head;
   logic     empty;
   logic     full;
   logic     valid [LOAD_DEPTH];
   reg_idx_t entries [LOAD_DEPTH];
   logic     p4_load;
   logic     p4_alu;
   logic     deq;
   logic     enq;
   logic     alu_wr;
   logic     hit_a;
   logic     hit_b;

   assign p4_load = p4_valid && p4_is_load;
   assign p4_alu  = p4_valid && !p4_is_load && (p4_dest_reg != '0);
   assign deq     = mem.mem_rvalid && !empty;
   assign p4_stall = (mem.mem_rvalid && p4_alu) || (p4_load && full);
   assign enq     = p4_load && !p4_stall;
   assign alu_wr  = p4_alu && !p4_stall;

   cpu_load_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .enq     (enq),
      .enq_tag (p4_dest_reg),
      .deq     (deq),
      .head    (head),
      .empty   (empty),
      .full    (full),
      .valid   (valid),
      .entries (entries)
   );

   // Operand hazard against every pending or about-to-issue load.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
         if (valid[i]) begin
            hit_a |= src_hit(p2_reg_a, entries[i]);
            hit_b |= src_hit(p2_reg_b, entries[i]);
         end
      end
      if (p4_load) begin
         hit_a |= src_hit(p2_reg_a, p4_dest_reg);
         hit_b |= src_hit(p2_reg_b, p4_dest_reg);
      end
      if (p3_is_load) begin
         hit_a |= src_hit(p2_reg_a, p3_dest_reg);
         hit_b |= src_hit(p2_reg_b, p3_dest_reg);
      end
      p2_stall = hit_a || (hit_b && !p2_literal_b);
   end

   // Register-file write port; idle cycles drive dest 0 and hold data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p5_dest_reg <= '0;
         p5_result   <= '0;
      end else if (deq) begin
         p5_dest_reg <= head;
         p5_result   <= mem.mem_rdata;
      end else if (alu_wr) begin
         p5_dest_reg <= p4_dest_reg;
         p5_result   <= p4_result;
      end else begin
         p5_dest_reg <= '0;
      end
   end

   // Sticky flag for a response with nothing outstanding.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) wb_error <= 1'b0;
      else if (mem.mem_rvalid && empty) wb_error <= 1'b1;
   end

endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 SHALL have parameter LOAD_DEPTH, default 4, meaning the number of loads that may be outstanding (power of 2, at least 2).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 p3_dest_reg  in  5; p3_is_load  in  1: the instruction in stage 3, used for hazard checks only.
REQ-005 p4_valid  in  1; p4_dest_reg  in  5; p4_result  in  32; p4_is_load  in  1: the instruction completing stage 4.
REQ-006 mem_rvalid  in  1; mem_rdata  in  32: in-order load responses from memory, already aligned and extended; they cannot be back-pressured.
REQ-007 p2_reg_a  in  5; p2_reg_b  in  5; p2_literal_b  in  1: the source operands being decoded.
REQ-008 p5_dest_reg  out  5; p5_result  out  32: the register file write port; dest 0 means no write.
REQ-009 p2_stall  out  1; p4_stall  out  1: combinational pipeline holds.
REQ-010 wb_error  out  1: sticky flag set when a load response arrives with no outstanding load.

Function
REQ-011 A load-tag FIFO SHALL hold the destination registers of issued loads, in issue order.
REQ-012 A stage-4 load (p4_valid and p4_is_load) that is not stalled SHALL enqueue p4_dest_reg, including dest 0, so that responses stay matched to their loads.
REQ-013 On mem_rvalid with the FIFO non-empty, the head SHALL be dequeued and, in the next cycle, p5_dest_reg SHALL equal the head tag and p5_result SHALL equal mem_rdata.
REQ-014 An ALU completion (p4_valid, not p4_is_load, not stalled) SHALL produce, in the next cycle, p5_dest_reg equal to p4_dest_reg and p5_result equal to p4_result.
REQ-015 In any cycle with no write, the next cycle SHALL have p5_dest_reg equal to 0; p5_result then holds its previous value.
REQ-016 A load response SHALL have priority for the write port.
REQ-017 p4_stall SHALL be asserted when mem_rvalid is high and p4_valid is high, p4_is_load is low and p4_dest_reg is not 0.
REQ-018 p4_stall SHALL also be asserted when p4_valid and p4_is_load are high and the FIFO count equals LOAD_DEPTH, even if a dequeue occurs in the same cycle.
REQ-019 An ALU instruction with dest 0 SHALL never stall and SHALL write nothing.
REQ-020 A simultaneous enqueue and dequeue SHALL leave the count unchanged; read and write pointers SHALL wrap modulo LOAD_DEPTH.
REQ-021 mem_rvalid with an empty FIFO (judged before any same-cycle enqueue) SHALL set wb_error, be dropped, and leave the FIFO unchanged.
REQ-022 p2_stall SHALL be asserted when a source register is non-zero and matches any valid FIFO entry, a valid stage-4 load dest, or p3_dest_reg while p3_is_load is high.
REQ-023 The source registers for REQ-022 are p2_reg_a always, and p2_reg_b only when p2_literal_b is low.
REQ-024 The FIFO entry being dequeued in the current cycle SHALL still count as pending for REQ-022, since its data reaches the register file only in the following cycle.
REQ-025 wb_error SHALL remain set until reset.

Reset
REQ-026 While reset is asserted the FIFO SHALL be empty, with pointers and count at 0.
REQ-027 While reset is asserted p5_dest_reg SHALL be 0, p5_result SHALL be 0, and wb_error SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding load tags; responses arriving after reset SHALL follow REQ-021.

Structure
REQ-029 The register-index typedef (5 bits) and the LOAD_DEPTH default SHALL reside in the shared package cpu_pkg.
REQ-030 The tag FIFO SHALL be a sub-module, cpu_load_fifo, that exposes its valid-entry vector and entries for the hazard comparators.

Verification
REQ-031 Issue an ALU op with dest 3 and result 0x12345678 -> the next cycle shows p5_dest_reg 3 and p5_result 0x12345678; no stalls.
REQ-032 Issue loads to 5 then 6, then responses 0xAAAA then 0xBBBB -> writes of 5=0xAAAA then 6=0xBBBB in order; p2_reg_a 5 stalls until the cycle after the first write.
REQ-033 A response arrives in the same cycle as an ALU op with dest 7 -> the load is written, p4_stall is 1 for one cycle, and register 7 is written in the following cycle.
REQ-034 Issue 4 loads with no response, then a fifth load -> p4_stall is held until the first response arrives, then the fifth load enqueues.
REQ-035 mem_rvalid with an empty FIFO -> wb_error is 1 and no write occurs; reset clears it to 0.
REQ-036 A load to dest 0 followed by a response -> no register write; p2_reg_a 0 never stalls.
